caliptra_axi_burst_initiator: RTL and testbench
===============================================

# caliptra_axi_burst_initiator

AXI4 manager that issues single-ID INCR bursts into the Caliptra AXI subordinate port (AW/W/B/AR/R, 32-bit address/data, 16-bit ID, 32-bit USER). It is used by FPGA-side test and loader logic to drive mailbox and register traffic without a soft CPU. A simple command/stream front end is converted into one outstanding AXI transaction at a time, and a status code is reported per command.

## Interface
- ID_W, 16, AXI ID width
- USER_W, 32, AxUSER width
- core_clk  in  1  clock for all logic
- core_rst  in  1  synchronous, active-high reset
- cmd_valid / cmd_ready  in/out  1/1  command handshake
- cmd_write  in  1  1 = write burst, 0 = read burst
- cmd_addr  in  32  start byte address
- cmd_len  in  8  beats minus one (AXI encoding)
- cmd_id  in  ID_W  AxID
- cmd_user  in  USER_W  AxUSER
- wr_valid / wr_ready  in/out  1/1  write-data stream handshake
- wr_data / wr_strb  in  32/4  write beat data and strobes
- rd_valid / rd_ready  out/in  1/1  read-data stream handshake
- rd_data  out  32  read beat data
- rd_last  out  1  final beat of the burst
- done  out  1  one-cycle pulse at command completion
- status  out  3  completion code, valid while done=1
- m_axi_aw{addr,burst,size,len,user,id,lock,valid}, m_axi_awready  out/in  AW channel
- m_axi_w{data,strb,last,valid}, m_axi_wready  out/in  W channel
- m_axi_b{resp[1:0],id,valid}, m_axi_bready  in/out  B channel
- m_axi_ar{addr,burst,size,len,user,id,lock,valid}, m_axi_arready  out/in  AR channel
- m_axi_r{data,resp[1:0],id,last,valid}, m_axi_rready  in/out  R channel

## Operation
- State machine: IDLE -> (write) AW -> WDATA -> BRESP -> DONE -> IDLE; (read) IDLE -> AR -> RDATA -> DONE -> IDLE; illegal command: IDLE -> DONE.
- cmd_ready=1 only in IDLE. On accept, addr/len/id/user/write are registered.
- Illegal command: cmd_addr[1:0]!=0, or cmd_addr[11:0] + 4*(cmd_len+1) > 4096 (4 KB crossing, computed in 13 bits). No AXI traffic is issued; status=5.
- Fixed fields: burst=2'b01 (INCR), size=3'b010, lock=0.
- AW/AR: valid is held with stable payload until ready is asserted.
- WDATA: m_axi_wvalid=wr_valid, wr_ready=m_axi_wready, data/strb pass through combinationally. A beat counter (9 bits, cleared on accept) increments on each W handshake. wlast=1 when count==len. After the last handshake, go to BRESP.
- BRESP: bready=1. Completion is on B handshake.
- RDATA: rd_valid=m_axi_rvalid, m_axi_rready=rd_ready, rd_data=rdata, rd_last=(count==len). The state is left on the handshake of beat len. An rlast mismatch does not end the burst early.
- Status latches the first error only: 0 OKAY; 1 SLVERR (resp=2'b10); 2 DECERR (2'b11); 3 B/R ID != cmd_id; 4 rlast != (count==len); 5 illegal command. EXOKAY (2'b01) is treated as OKAY.
- Read errors do not stop data forwarding; all len+1 beats are delivered.

## Timing
- Reset values: cmd_ready=0 in the reset cycle and 1 after; every other valid/ready/last/done=0; status=0; counter=0; state=IDLE.
- A reset asserted mid-burst forces all AXI valids/readies low on the next edge. The transaction is abandoned and no done is issued.
- Accept at edge N: awvalid/arvalid=1 from N+1. Minimum write latency is accept -> done at B-handshake edge +1. done is high only in DONE (one cycle). cmd_ready returns the cycle after done.
- Illegal command: done is asserted the cycle after accept.
- No combinational path from AXI inputs to AXI outputs except the pass-through of W/R valid/ready/data.
- cmd_valid is ignored outside IDLE. wr_ready=0 and rd_valid=0 outside WDATA/RDATA.

## Test plan
- Single-beat write, addr 0x3000_0000, len 0, data 0xDEADBEEF, strb 0xF, bresp OKAY -> one AW (len 0, INCR, size 2), one W with wlast=1, done with status 0.
- 4-beat read, addr 0x3000_0010, id 0x0005, R beats 0x11..0x44 with rlast on the 4th -> rd_data sequence 0x11,0x22,0x33,0x44, rd_last on the 4th, status 0.
- Backpressure: awready delayed 3 cycles, random wready/rd_ready -> payload stable while valid=1, beat count exact, no lost or duplicated beats.
- Errors: bresp=2'b10 gives status 1. Read beat 2 of 4 with rresp=2'b11 and beat 3 with a wrong rid gives status 2 (first error) and all 4 beats delivered.
- Illegal command: addr 0x0000_0FF8 len 3, or addr 0x2 -> no AW/AR issued, done the cycle after accept, status 5.
- Reset during WDATA after beat 1 of 8 -> wvalid/awvalid low next cycle, no done, next command executes normally.

Source files
------------

// File: rtl/caliptra_axi_burst_initiator.sv
// caliptra_axi_burst_initiator: command/stream front end driving one
// outstanding AXI4 INCR burst at a time into the Caliptra subordinate port.
module caliptra_axi_burst_initiator #(
  parameter int ID_W   = 16,
  parameter int USER_W = 32
) (
  input  logic              core_clk,
  input  logic              core_rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [31:0]       cmd_addr,
  input  logic [7:0]        cmd_len,
  input  logic [ID_W-1:0]   cmd_id,
  input  logic [USER_W-1:0] cmd_user,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [31:0]       wr_data,
  input  logic [3:0]        wr_strb,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [31:0]       rd_data,
  output logic              rd_last,
  output logic              done,
  output logic [2:0]        status,
  output logic [31:0]       m_axi_awaddr,
  output logic [1:0]        m_axi_awburst,
  output logic [2:0]        m_axi_awsize,
  output logic [7:0]        m_axi_awlen,
  output logic [USER_W-1:0] m_axi_awuser,
  output logic [ID_W-1:0]   m_axi_awid,
  output logic              m_axi_awlock,
  output logic              m_axi_awvalid,
  input  logic              m_axi_awready,
  output logic [31:0]       m_axi_wdata,
  output logic [3:0]        m_axi_wstrb,
  output logic              m_axi_wlast,
  output logic              m_axi_wvalid,
  input  logic              m_axi_wready,
  input  logic [1:0]        m_axi_bresp,
  input  logic [ID_W-1:0]   m_axi_bid,
  input  logic              m_axi_bvalid,
  output logic              m_axi_bready,
  output logic [31:0]       m_axi_araddr,
  output logic [1:0]        m_axi_arburst,
  output logic [2:0]        m_axi_arsize,
  output logic [7:0]        m_axi_arlen,
  output logic [USER_W-1:0] m_axi_aruser,
  output logic [ID_W-1:0]   m_axi_arid,
  output logic              m_axi_arlock,
  output logic              m_axi_arvalid,
  input  logic              m_axi_arready,
  input  logic [31:0]       m_axi_rdata,
  input  logic [1:0]        m_axi_rresp,
  input  logic [ID_W-1:0]   m_axi_rid,
  input  logic              m_axi_rlast,
  input  logic              m_axi_rvalid,
  output logic              m_axi_rready
);

  typedef enum logic [2:0] {
    S_IDLE, S_AW, S_WDATA, S_BRESP, S_AR, S_RDATA, S_DONE
  } state_t;

  state_t state, state_nx;

  logic [31:0]       addr_q;
  logic [7:0]        len_q;
  logic [ID_W-1:0]   id_q;
  logic [USER_W-1:0] user_q;
  logic [8:0]        cnt;
  logic [2:0]        st_q;
  logic [2:0]        err;
  logic [12:0]       end_off;
  logic              accept, illegal, last_beat;
  logic              w_hs, r_hs, b_hs;

  function automatic logic [2:0] resp_err(input logic [1:0] resp);
    logic [2:0] e;
    unique case (resp)
      2'b10:   e = 3'd1;
      2'b11:   e = 3'd2;
      default: e = 3'd0;
    endcase
    return e;
  endfunction

  // One past the last byte offset within the 4 KB page, 13 bits wide
  assign end_off = {1'b0, cmd_addr[11:0]}
                 + {3'b000, cmd_len, 2'b00} + 13'd4;
  assign illegal = (cmd_addr[1:0] != 2'b00)
                || (end_off > 13'd4096);

  assign cmd_ready = (state == S_IDLE) && !core_rst;
  assign accept    = cmd_valid && cmd_ready;
  assign last_beat = (cnt == {1'b0, len_q});
  assign w_hs = (state == S_WDATA) && wr_valid && m_axi_wready;
  assign r_hs = (state == S_RDATA) && m_axi_rvalid && rd_ready;
  assign b_hs = (state == S_BRESP) && m_axi_bvalid;

  always_comb begin
    err = 3'd0;
    if (b_hs) begin
      err = resp_err(m_axi_bresp);
      if (err == 3'd0 && m_axi_bid != id_q) err = 3'd3;
    end else if (r_hs) begin
      err = resp_err(m_axi_rresp);
      if (err == 3'd0 && m_axi_rid != id_q) err = 3'd3;
      if (err == 3'd0 && m_axi_rlast != last_beat) err = 3'd4;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:
        if (accept)
          state_nx = illegal ? S_DONE : (cmd_write ? S_AW : S_AR);
      S_AW:    if (m_axi_awready) state_nx = S_WDATA;
      S_WDATA: if (w_hs && last_beat) state_nx = S_BRESP;
      S_BRESP: if (m_axi_bvalid) state_nx = S_DONE;
      S_AR:    if (m_axi_arready) state_nx = S_RDATA;
      S_RDATA: if (r_hs && last_beat) state_nx = S_DONE;
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge core_clk) begin
    if (core_rst) begin
      state  <= S_IDLE;
      addr_q <= '0;
      len_q  <= '0;
      id_q   <= '0;
      user_q <= '0;
      cnt    <= '0;
      st_q   <= '0;
    end else begin
      state <= state_nx;
      if (accept) begin
        addr_q <= cmd_addr;
        len_q  <= cmd_len;
        id_q   <= cmd_id;
        user_q <= cmd_user;
        cnt    <= '0;
        st_q   <= illegal ? 3'd5 : 3'd0;
      end else begin
        if (w_hs || r_hs) cnt <= cnt + 9'd1;
        // Only the first error of a command is kept
        if (st_q == 3'd0 && err != 3'd0) st_q <= err;
      end
    end
  end

  assign m_axi_awaddr  = addr_q;
  assign m_axi_awburst = 2'b01;
  assign m_axi_awsize  = 3'b010;
  assign m_axi_awlen   = len_q;
  assign m_axi_awuser  = user_q;
  assign m_axi_awid    = id_q;
  assign m_axi_awlock  = 1'b0;
  assign m_axi_awvalid = (state == S_AW);

  assign m_axi_wdata  = wr_data;
  assign m_axi_wstrb  = wr_strb;
  assign m_axi_wlast  = (state == S_WDATA) && last_beat;
  assign m_axi_wvalid = (state == S_WDATA) && wr_valid;
  assign wr_ready     = (state == S_WDATA) && m_axi_wready;
  assign m_axi_bready = (state == S_BRESP);

  assign m_axi_araddr  = addr_q;
  assign m_axi_arburst = 2'b01;
  assign m_axi_arsize  = 3'b010;
  assign m_axi_arlen   = len_q;
  assign m_axi_aruser  = user_q;
  assign m_axi_arid    = id_q;
  assign m_axi_arlock  = 1'b0;
  assign m_axi_arvalid = (state == S_AR);

  assign rd_valid     = (state == S_RDATA) && m_axi_rvalid;
  assign m_axi_rready = (state == S_RDATA) && rd_ready;
  assign rd_data      = m_axi_rdata;
  assign rd_last      = (state == S_RDATA) && last_beat;

  assign done   = (state == S_DONE);
  assign status = st_q;

endmodule

// File: tb/tb_caliptra_axi_burst_initiator.sv
// tb_caliptra_axi_burst_initiator: randomized scoreboard bench with a
// behavioural AXI subordinate and per-command status reference model.
module tb_caliptra_axi_burst_initiator;

  logic        core_clk, core_rst;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr;
  logic [7:0]  cmd_len;
  logic [15:0] cmd_id;
  logic [31:0] cmd_user;
  logic        wr_valid, wr_ready;
  logic [31:0] wr_data;
  logic [3:0]  wr_strb;
  logic        rd_valid, rd_ready;
  logic [31:0] rd_data;
  logic        rd_last, done;
  logic [2:0]  status;
  logic [31:0] m_axi_awaddr, m_axi_araddr;
  logic [1:0]  m_axi_awburst, m_axi_arburst;
  logic [2:0]  m_axi_awsize, m_axi_arsize;
  logic [7:0]  m_axi_awlen, m_axi_arlen;
  logic [31:0] m_axi_awuser, m_axi_aruser;
  logic [15:0] m_axi_awid, m_axi_arid;
  logic        m_axi_awlock, m_axi_awvalid, m_axi_awready;
  logic        m_axi_arlock, m_axi_arvalid, m_axi_arready;
  logic [31:0] m_axi_wdata, m_axi_rdata;
  logic [3:0]  m_axi_wstrb;
  logic        m_axi_wlast, m_axi_wvalid, m_axi_wready;
  logic [1:0]  m_axi_bresp, m_axi_rresp;
  logic [15:0] m_axi_bid, m_axi_rid;
  logic        m_axi_bvalid, m_axi_bready;
  logic        m_axi_rlast, m_axi_rvalid, m_axi_rready;

  caliptra_axi_burst_initiator dut (
    .core_clk(core_clk), .core_rst(core_rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_write(cmd_write), .cmd_addr(cmd_addr),
    .cmd_len(cmd_len), .cmd_id(cmd_id), .cmd_user(cmd_user),
    .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_data(wr_data), .wr_strb(wr_strb),
    .rd_valid(rd_valid), .rd_ready(rd_ready),
    .rd_data(rd_data), .rd_last(rd_last),
    .done(done), .status(status),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awburst(m_axi_awburst),
    .m_axi_awsize(m_axi_awsize), .m_axi_awlen(m_axi_awlen),
    .m_axi_awuser(m_axi_awuser), .m_axi_awid(m_axi_awid),
    .m_axi_awlock(m_axi_awlock), .m_axi_awvalid(m_axi_awvalid),
    .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
    .m_axi_wlast(m_axi_wlast), .m_axi_wvalid(m_axi_wvalid),
    .m_axi_wready(m_axi_wready),
    .m_axi_bresp(m_axi_bresp), .m_axi_bid(m_axi_bid),
    .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
    .m_axi_araddr(m_axi_araddr), .m_axi_arburst(m_axi_arburst),
    .m_axi_arsize(m_axi_arsize), .m_axi_arlen(m_axi_arlen),
    .m_axi_aruser(m_axi_aruser), .m_axi_arid(m_axi_arid),
    .m_axi_arlock(m_axi_arlock), .m_axi_arvalid(m_axi_arvalid),
    .m_axi_arready(m_axi_arready),
    .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
    .m_axi_rid(m_axi_rid), .m_axi_rlast(m_axi_rlast),
    .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
  );

  initial begin
    core_clk = 1'b0;
    forever #5 core_clk = ~core_clk;
  end

  int tests = 0;
  int errors = 0;
  int done_seen = 0;

  logic [93:0] exp_aw[$];
  logic [93:0] exp_ar[$];
  logic [36:0] exp_w[$];
  logic [32:0] exp_rd[$];
  logic [2:0]  exp_st[$];

  // Subordinate behaviour for the command in flight
  logic [31:0] wdat[256];
  logic [3:0]  wstb[256];
  logic [31:0] rdat[256];
  logic [1:0]  rrsp[256];
  logic [15:0] rid_a[256];
  logic        rlst[256];
  logic [1:0]  bresp_v;
  logic [15:0] bid_v;
  int          aw_delay;

  logic [93:0] aw_pay, ar_pay;
  assign aw_pay = {m_axi_awaddr, m_axi_awlen, m_axi_awid, m_axi_awuser,
                   m_axi_awburst, m_axi_awsize, m_axi_awlock};
  assign ar_pay = {m_axi_araddr, m_axi_arlen, m_axi_arid, m_axi_aruser,
                   m_axi_arburst, m_axi_arsize, m_axi_arlock};

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] req);
    tests++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", nm, act, req);
    end
  endtask

  task automatic fail(input string nm);
    tests++;
    errors++;
    $display("FAIL %s: got timeout or unexpected event, required none", nm);
  endtask

  function automatic logic [2:0] code_of(input logic [1:0] r);
    return (r == 2'b10) ? 3'd1 : (r == 2'b11) ? 3'd2 : 3'd0;
  endfunction

  task automatic plan(input int l, input logic [15:0] id, input bit noisy);
    for (int i = 0; i <= l; i++) begin
      wdat[i]  = $urandom;
      wstb[i]  = 4'($urandom_range(15));
      rdat[i]  = $urandom;
      rrsp[i]  = 2'b00;
      rid_a[i] = id;
      rlst[i]  = (i == l);
      if (noisy) begin
        if ($urandom_range(9) == 0) rrsp[i] = 2'($urandom_range(3));
        if ($urandom_range(19) == 0) rid_a[i] = id ^ 16'h0001;
        if ($urandom_range(19) == 0) rlst[i] = !rlst[i];
      end
    end
    bresp_v  = 2'b00;
    bid_v    = id;
    aw_delay = noisy ? int'($urandom_range(3)) : 0;
    if (noisy && $urandom_range(4) == 0) bresp_v = 2'($urandom_range(3));
    if (noisy && $urandom_range(9) == 0) bid_v = id ^ 16'h0008;
  endtask

  task automatic issue();
    int g = 0;
    bit hs = 0;
    cmd_valid = 1'b1;
    while (!hs && g < 20) begin
      @(negedge core_clk);
      hs = cmd_ready;
      @(posedge core_clk); #1;
      g++;
    end
    cmd_valid = 1'b0;
    if (!hs) fail("cmd_accept_timeout");
  endtask

  task automatic feed_w(input int n);
    int i = 0;
    int g = 0;
    while (i < n && g < 2000) begin
      wr_valid = ($urandom_range(3) != 0);
      wr_data  = wdat[i];
      wr_strb  = wstb[i];
      @(negedge core_clk);
      if (wr_valid && wr_ready) i++;
      @(posedge core_clk); #1;
      g++;
    end
    wr_valid = 1'b0;
    if (i < n) fail("wr_stream_timeout");
  endtask

  task automatic slave_w(input int n);
    int c = 0;
    int g = 0;
    int i = 0;
    bit hs = 0;
    while (!hs && g < 500) begin
      m_axi_awready = (c >= aw_delay);
      @(negedge core_clk);
      hs = m_axi_awvalid && m_axi_awready;
      if (m_axi_awvalid) c++;
      @(posedge core_clk); #1;
      g++;
    end
    m_axi_awready = 1'b0;
    while (i < n && g < 2000) begin
      m_axi_wready = ($urandom_range(3) != 0);
      @(negedge core_clk);
      if (m_axi_wvalid && m_axi_wready) i++;
      @(posedge core_clk); #1;
      g++;
    end
    m_axi_wready = 1'b0;
    m_axi_bvalid = 1'b1;
    m_axi_bresp  = bresp_v;
    m_axi_bid    = bid_v;
    hs = 0;
    while (!hs && g < 2100) begin
      @(negedge core_clk);
      hs = m_axi_bvalid && m_axi_bready;
      @(posedge core_clk); #1;
      g++;
    end
    m_axi_bvalid = 1'b0;
    if (!hs) fail("axi_write_timeout");
  endtask

  task automatic slave_r(input int n);
    int c = 0;
    int g = 0;
    int i = 0;
    bit hs = 0;
    while (!hs && g < 500) begin
      m_axi_arready = (c >= aw_delay);
      @(negedge core_clk);
      hs = m_axi_arvalid && m_axi_arready;
      if (m_axi_arvalid) c++;
      @(posedge core_clk); #1;
      g++;
    end
    m_axi_arready = 1'b0;
    while (i < n && g < 2000) begin
      m_axi_rvalid = ($urandom_range(3) != 0);
      m_axi_rdata  = rdat[i];
      m_axi_rresp  = rrsp[i];
      m_axi_rid    = rid_a[i];
      m_axi_rlast  = rlst[i];
      @(negedge core_clk);
      if (m_axi_rvalid && m_axi_rready) i++;
      @(posedge core_clk); #1;
      g++;
    end
    m_axi_rvalid = 1'b0;
    if (i < n) fail("axi_read_timeout");
  endtask

  task automatic sink_r(input int n);
    int i = 0;
    int g = 0;
    while (i < n && g < 2000) begin
      rd_ready = ($urandom_range(3) != 0);
      @(negedge core_clk);
      if (rd_valid && rd_ready) i++;
      @(posedge core_clk); #1;
      g++;
    end
    rd_ready = 1'b0;
    if (i < n) fail("rd_stream_timeout");
  endtask

  // Expectations come from the command and the subordinate plan alone
  task automatic run_cmd(input logic w, input logic [31:0] a,
                         input logic [7:0] l, input logic [15:0] id,
                         input logic [31:0] u);
    int n, d0, g;
    bit ill;
    logic [2:0] st, e;
    n = int'(l) + 1;
    ill = (a[1:0] != 2'b00) || (int'(a[11:0]) + 4 * n > 4096);
    st = 3'd0;
    if (ill) st = 3'd5;
    else if (w) begin
      exp_aw.push_back({a, l, id, u, 2'b01, 3'b010, 1'b0});
      for (int i = 0; i < n; i++)
        exp_w.push_back({wdat[i], wstb[i], i == n - 1});
      st = code_of(bresp_v);
      if (st == 3'd0 && bid_v != id) st = 3'd3;
    end else begin
      exp_ar.push_back({a, l, id, u, 2'b01, 3'b010, 1'b0});
      for (int i = 0; i < n; i++) begin
        exp_rd.push_back({rdat[i], i == n - 1});
        e = code_of(rrsp[i]);
        if (e == 3'd0 && rid_a[i] != id) e = 3'd3;
        if (e == 3'd0 && rlst[i] != (i == n - 1)) e = 3'd4;
        if (st == 3'd0) st = e;
      end
    end
    exp_st.push_back(st);
    d0 = done_seen;
    cmd_write = w;
    cmd_addr  = a;
    cmd_len   = l;
    cmd_id    = id;
    cmd_user  = u;
    issue();
    if (ill) begin
      @(negedge core_clk);
      chk("illegal_done_latency", 128'(done), 128'(1));
      @(posedge core_clk); #1;
    end else if (w) begin
      fork
        feed_w(n);
        slave_w(n);
      join
    end else begin
      fork
        slave_r(n);
        sink_r(n);
      join
    end
    g = 0;
    while (done_seen == d0 && g < 100) begin
      @(posedge core_clk); #1;
      g++;
    end
    if (done_seen == d0) fail("done_timeout");
  endtask

  initial begin
    logic [93:0] aw_prev, ar_prev;
    bit aw_hold, ar_hold;
    aw_hold = 0;
    ar_hold = 0;
    forever begin
      @(negedge core_clk);
      if (core_rst) begin
        aw_hold = 0;
        ar_hold = 0;
      end else begin
        if (aw_hold) begin
          if (!m_axi_awvalid) fail("aw_dropped");
          else chk("aw_stable", 128'(aw_pay), 128'(aw_prev));
        end
        aw_hold = 0;
        if (m_axi_awvalid) begin
          if (exp_aw.size() == 0) fail("aw_unexpected");
          else if (m_axi_awready)
            chk("aw", 128'(aw_pay), 128'(exp_aw.pop_front()));
          else begin
            aw_hold = 1;
            aw_prev = aw_pay;
          end
        end
        if (ar_hold) begin
          if (!m_axi_arvalid) fail("ar_dropped");
          else chk("ar_stable", 128'(ar_pay), 128'(ar_prev));
        end
        ar_hold = 0;
        if (m_axi_arvalid) begin
          if (exp_ar.size() == 0) fail("ar_unexpected");
          else if (m_axi_arready)
            chk("ar", 128'(ar_pay), 128'(exp_ar.pop_front()));
          else begin
            ar_hold = 1;
            ar_prev = ar_pay;
          end
        end
        if (m_axi_wvalid && m_axi_wready) begin
          if (exp_w.size() == 0) fail("w_unexpected");
          else chk("w_beat", 128'({m_axi_wdata, m_axi_wstrb, m_axi_wlast}),
                   128'(exp_w.pop_front()));
        end
        if (rd_valid && rd_ready) begin
          if (exp_rd.size() == 0) fail("rd_unexpected");
          else chk("rd_beat", 128'({rd_data, rd_last}),
                   128'(exp_rd.pop_front()));
        end
        if (done) begin
          done_seen++;
          if (exp_st.size() == 0) fail("done_unexpected");
          else chk("status", 128'(status), 128'(exp_st.pop_front()));
        end
      end
    end
  end

  initial begin
    int g;
    bit hs;
    logic w;
    logic [31:0] a;
    logic [7:0] l;
    logic [15:0] id;
    core_rst = 1'b1;
    cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_len = 0;
    cmd_id = 0; cmd_user = 0;
    wr_valid = 0; wr_data = 0; wr_strb = 0; rd_ready = 0;
    m_axi_awready = 0; m_axi_wready = 0; m_axi_arready = 0;
    m_axi_bresp = 0; m_axi_bid = 0; m_axi_bvalid = 0;
    m_axi_rdata = 0; m_axi_rresp = 0; m_axi_rid = 0;
    m_axi_rlast = 0; m_axi_rvalid = 0;
    repeat (3) @(posedge core_clk);
    @(negedge core_clk);
    chk("reset_outputs",
        128'({cmd_ready, m_axi_awvalid, m_axi_arvalid, m_axi_wvalid,
              m_axi_wlast, m_axi_bready, m_axi_rready, wr_ready,
              rd_valid, rd_last, done, status}), 128'(0));
    @(posedge core_clk); #1;
    core_rst = 1'b0;
    @(negedge core_clk);
    chk("reset_release_ready", 128'(cmd_ready), 128'(1));
    @(posedge core_clk); #1;

    plan(0, 16'h0001, 0);
    wdat[0] = 32'hDEAD_BEEF;
    wstb[0] = 4'hF;
    run_cmd(1, 32'h3000_0000, 8'd0, 16'h0001, 32'h0000_00A5);

    plan(3, 16'h0005, 0);
    rdat[0] = 32'h11; rdat[1] = 32'h22; rdat[2] = 32'h33; rdat[3] = 32'h44;
    run_cmd(0, 32'h3000_0010, 8'd3, 16'h0005, 32'h1234_5678);

    plan(7, 16'h0007, 0);
    aw_delay = 3;
    run_cmd(1, 32'h3000_0200, 8'd7, 16'h0007, 32'h0);
    aw_delay = 3;
    run_cmd(0, 32'h3000_0400, 8'd7, 16'h0007, 32'h0);

    plan(1, 16'h0002, 0);
    bresp_v = 2'b10;
    run_cmd(1, 32'h3000_0040, 8'd1, 16'h0002, 32'h0);

    plan(3, 16'h0009, 0);
    rrsp[1] = 2'b11;
    rid_a[2] = 16'h0019;
    run_cmd(0, 32'h3000_0080, 8'd3, 16'h0009, 32'h0);

    run_cmd(1, 32'h0000_0FF8, 8'd3, 16'h0003, 32'h0);
    run_cmd(0, 32'h0000_0002, 8'd0, 16'h0003, 32'h0);
    plan(1, 16'h0004, 0);
    run_cmd(0, 32'h0000_0FF8, 8'd1, 16'h0004, 32'h0);

    // Abandon a write burst mid-stream with reset
    plan(7, 16'h0033, 0);
    exp_aw.push_back({32'h3000_0100, 8'd7, 16'h0033, 32'h0,
                      2'b01, 3'b010, 1'b0});
    exp_w.push_back({wdat[0], wstb[0], 1'b0});
    cmd_write = 1; cmd_addr = 32'h3000_0100; cmd_len = 8'd7;
    cmd_id = 16'h0033; cmd_user = 32'h0;
    issue();
    m_axi_awready = 1; m_axi_wready = 1;
    wr_valid = 1; wr_data = wdat[0]; wr_strb = wstb[0];
    g = 0;
    hs = 0;
    while (!hs && g < 50) begin
      @(negedge core_clk);
      hs = m_axi_wvalid && m_axi_wready;
      @(posedge core_clk); #1;
      g++;
    end
    if (!hs) fail("rst_first_beat_timeout");
    core_rst = 1'b1;
    m_axi_wready = 0;
    m_axi_awready = 0;
    @(posedge core_clk);
    @(negedge core_clk);
    chk("rst_mid_burst",
        128'({m_axi_awvalid, m_axi_wvalid, wr_ready, done, cmd_ready}),
        128'(0));
    @(posedge core_clk); #1;
    core_rst = 1'b0;
    wr_valid = 0;
    @(negedge core_clk);
    chk("rst_mid_ready", 128'(cmd_ready), 128'(1));
    @(posedge core_clk); #1;

    plan(2, 16'h0044, 0);
    run_cmd(1, 32'h3000_0300, 8'd2, 16'h0044, 32'h0);

    for (int k = 0; k < 40; k++) begin
      w  = 1'($urandom_range(1));
      l  = 8'($urandom_range(15));
      id = 16'($urandom);
      a  = $urandom;
      a[1:0] = 2'b00;
      if ($urandom_range(7) == 0) a[1:0] = 2'($urandom_range(3));
      if ($urandom_range(5) == 0)
        a[11:2] = 10'(1024 - int'($urandom_range(20)));
      plan(int'(l), id, 1);
      run_cmd(w, a, l, id, $urandom);
      repeat ($urandom_range(2)) begin
        @(posedge core_clk); #1;
      end
    end

    repeat (4) @(posedge core_clk);
    @(negedge core_clk);
    chk("queues_drained",
        128'(exp_aw.size() + exp_ar.size() + exp_w.size()
             + exp_rd.size() + exp_st.size()), 128'(0));
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
